// File: rtl/datapath_control_fsm_if.sv
// -----------------------------------------------------------------------------
// datapath_control_fsm_if
//   Control bundle between the multi-cycle control unit and the datapath.
//   The datapath feeds back the decoded instruction fields. The control unit
//   drives the per-step enables and mux selects.
//
//   Signals
//     run           datapath/host -> ctrl  1 = execute instructions continuously
//     opcode        datapath -> ctrl       instr[6:0]
//     funct3        datapath -> ctrl       instr[14:12]
//     funct7_5      datapath -> ctrl       instr[30], selects sub for R-type
//     load_ir       ctrl -> datapath       instruction register load enable
//     sub           ctrl -> datapath       ALU subtract
//     ULA_din2_sel  ctrl -> datapath       ALU operand 2: 1 = immediate, 0 = rs2
//     RF_din_sel    ctrl -> datapath       RF write data: 1 = ALU, 0 = memory
//     WE_RF         ctrl -> datapath       register-file write enable
//     WE_MEM        ctrl -> datapath       data-memory write enable
//     load_pc       ctrl -> datapath       PC <= PC+4 enable
//     reset_pc      ctrl -> datapath       PC clear
//
//   Modports
//     master  control unit side
//     slave   datapath side
// -----------------------------------------------------------------------------
interface datapath_control_fsm_if;
   logic       run;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5;
   logic       load_ir;
   logic       sub;
   logic       ULA_din2_sel;
   logic       RF_din_sel;
   logic       WE_RF;
   logic       WE_MEM;
   logic       load_pc;
   logic       reset_pc;

   modport master (
      input  run, opcode, funct3, funct7_5,
      output load_ir, sub, ULA_din2_sel, RF_din_sel,
             WE_RF, WE_MEM, load_pc, reset_pc
   );

   modport slave (
      output run, opcode, funct3, funct7_5,
      input  load_ir, sub, ULA_din2_sel, RF_din_sel,
             WE_RF, WE_MEM, load_pc, reset_pc
   );
endinterface

// File: rtl/datapath_control_fsm.sv
// -----------------------------------------------------------------------------
// datapath_control_fsm
//   Multi-cycle control unit for datapath_with_instructions. The unit fetches
//   an instruction, decodes it into an instruction class, and then steps
//   through EXEC / MEM / WB while it drives the datapath enables. It supports
//   ld, st, add, sub and addi. Any other encoding parks the unit in HALT with a
//   sticky illegal flag until reset.
//
//   Parameters
//     MEM_WAIT  extra wait cycles in MEM before the access completes (0..15)
//     CNT_W     width of the retired-instruction counter
//
//   Ports
//     i_clk          clock; all state changes on the rising edge
//     i_reset        synchronous, active-high reset
//     io_ctrl        control bundle (master side), see datapath_control_fsm_if
//     o_busy         1 in every state except IDLE and HALT
//     o_instr_done   one-cycle pulse as an instruction retires
//     o_illegal      sticky; set on an undecodable instruction
//     o_instr_count  retired-instruction count; wraps to 0
// -----------------------------------------------------------------------------
module datapath_control_fsm #(
   parameter int unsigned MEM_WAIT = 0,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   datapath_control_fsm_if.master io_ctrl,
   output logic                   o_busy,
   output logic                   o_instr_done,
   output logic                   o_illegal,
   output logic [CNT_W-1:0]       o_instr_count
);

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      C_NONE, C_LD, C_ST, C_ADD, C_SUB, C_ADDI
   } class_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [2:0] F3_WORD   = 3'b010;
   localparam logic [2:0] F3_ADD    = 3'b000;
   localparam logic [3:0] MEM_LAST  = 4'(MEM_WAIT);

   state_t           r_state;
   class_t           r_class;
   logic [3:0]       r_wait_cnt;
   logic             r_illegal;
   logic [CNT_W-1:0] r_instr_count;

   state_t           w_state_nxt;
   class_t           w_class_nxt;
   class_t           w_class_dec;
   logic [3:0]       w_wait_nxt;
   logic             w_illegal_nxt;
   logic             w_mux_en;
   logic             w_retire;
   logic             w_load_ir;
   logic             w_sub;
   logic             w_alu_imm;
   logic             w_rf_alu;
   logic             w_we_rf;
   logic             w_we_mem;
   logic             w_reset_pc;

   // Instruction decoder: pure function of the fetched fields.
   // NOTE: every combinational output gets a default before any branch so that
   // no path leaves it unassigned, which would infer a latch.
   always_comb begin
      w_class_dec = C_NONE;
      if (io_ctrl.opcode == OP_LOAD && io_ctrl.funct3 == F3_WORD) begin
         w_class_dec = C_LD;
      end else if (io_ctrl.opcode == OP_STORE && io_ctrl.funct3 == F3_WORD) begin
         w_class_dec = C_ST;
      end else if (io_ctrl.opcode == OP_RTYPE && io_ctrl.funct3 == F3_ADD) begin
         w_class_dec = io_ctrl.funct7_5 ? C_SUB : C_ADD;
      end else if (io_ctrl.opcode == OP_ITYPE && io_ctrl.funct3 == F3_ADD) begin
         w_class_dec = C_ADDI;
      end
   end

   // Next-state and Moore output decode.
   always_comb begin
      w_state_nxt   = r_state;
      w_class_nxt   = r_class;
      w_wait_nxt    = '0;
      w_illegal_nxt = r_illegal;
      w_mux_en      = 1'b0;
      w_retire      = 1'b0;
      w_load_ir     = 1'b0;
      w_we_rf       = 1'b0;
      w_we_mem      = 1'b0;
      w_reset_pc    = 1'b0;

      case (r_state)
         S_INIT: begin
            w_reset_pc  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         S_IDLE: begin
            if (io_ctrl.run) w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            w_load_ir   = 1'b1;
            w_state_nxt = S_DECODE;
         end
         S_DECODE: begin
            w_class_nxt = w_class_dec;
            if (w_class_dec == C_NONE) begin
               w_illegal_nxt = 1'b1;
               w_state_nxt   = S_HALT;
            end else begin
               w_state_nxt   = S_EXEC;
            end
         end
         S_EXEC: begin
            w_mux_en    = 1'b1;
            w_state_nxt = (r_class == C_LD || r_class == C_ST) ? S_MEM : S_WB;
         end
         S_MEM: begin
            w_mux_en = 1'b1;
            if (r_wait_cnt == MEM_LAST) begin
               if (r_class == C_ST) begin
                  w_we_mem = 1'b1;
                  w_retire = 1'b1;
               end else begin
                  w_state_nxt = S_WB;
               end
            end else begin
               w_wait_nxt = r_wait_cnt + 4'd1;
            end
         end
         S_WB: begin
            w_mux_en = 1'b1;
            w_we_rf  = 1'b1;
            w_retire = 1'b1;
         end
         S_HALT: begin
            w_state_nxt = S_HALT;
         end
         default: begin
            w_state_nxt = S_INIT;
         end
      endcase

      if (w_retire) w_state_nxt = io_ctrl.run ? S_FETCH : S_IDLE;

      // Reset can land in the last cycle of an instruction. Masking the
      // write enables and the retire pulse here stops a half-finished
      // instruction from committing on the same edge that resets the unit.
      if (i_reset) begin
         w_we_rf  = 1'b0;
         w_we_mem = 1'b0;
         w_retire = 1'b0;
      end
   end

   // Mux selects take their class values from EXEC through the last cycle.
   // Outside that window they idle at 0.
   always_comb begin
      w_sub     = 1'b0;
      w_alu_imm = 1'b0;
      w_rf_alu  = 1'b0;
      if (w_mux_en) begin
         w_sub     = (r_class == C_SUB);
         w_alu_imm = (r_class == C_LD || r_class == C_ST || r_class == C_ADDI);
         w_rf_alu  = (r_class != C_LD);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= S_INIT;
         r_class       <= C_NONE;
         r_wait_cnt    <= '0;
         r_illegal     <= 1'b0;
         r_instr_count <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_class    <= w_class_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_illegal  <= w_illegal_nxt;
         if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
      end
   end

   assign io_ctrl.load_ir      = w_load_ir;
   assign io_ctrl.sub          = w_sub;
   assign io_ctrl.ULA_din2_sel = w_alu_imm;
   assign io_ctrl.RF_din_sel   = w_rf_alu;
   assign io_ctrl.WE_RF        = w_we_rf;
   assign io_ctrl.WE_MEM       = w_we_mem;
   assign io_ctrl.load_pc      = w_retire;
   assign io_ctrl.reset_pc     = w_reset_pc;

   assign o_busy        = (r_state != S_IDLE) && (r_state != S_HALT);
   assign o_instr_done  = w_retire;
   assign o_illegal     = r_illegal;
   assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_datapath_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_datapath_control_fsm
//   Directed bench for datapath_control_fsm. It uses two instances:
//   dut0 (MEM_WAIT=0, CNT_W=16) and dut1 (MEM_WAIT=3, CNT_W=3).
//   Each instruction pushes its expected footprint to a scoreboard queue.
//   The bench pops and compares that footprint when the DUT retires the
//   instruction.
// -----------------------------------------------------------------------------
module tb_datapath_control_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rst1, run0, run1;
   logic [6:0] opc;
   logic [2:0] f3;
   logic       f7;

   datapath_control_fsm_if bus0 ();
   datapath_control_fsm_if bus1 ();

   assign bus0.run = run0;  assign bus0.opcode = opc;
   assign bus0.funct3 = f3; assign bus0.funct7_5 = f7;
   assign bus1.run = run1;  assign bus1.opcode = opc;
   assign bus1.funct3 = f3; assign bus1.funct7_5 = f7;

   logic        busy0, done0, ill0, busy1, done1, ill1;
   logic [15:0] cnt0;
   logic [2:0]  cnt1;

   datapath_control_fsm #(.MEM_WAIT(0), .CNT_W(16)) dut0 (
      .i_clk(clk), .i_reset(rst0), .io_ctrl(bus0.master),
      .o_busy(busy0), .o_instr_done(done0), .o_illegal(ill0), .o_instr_count(cnt0)
   );

   datapath_control_fsm #(.MEM_WAIT(3), .CNT_W(3)) dut1 (
      .i_clk(clk), .i_reset(rst1), .io_ctrl(bus1.master),
      .o_busy(busy1), .o_instr_done(done1), .o_illegal(ill1), .o_instr_count(cnt1)
   );

   // Observation mux: sel picks which instance the scoreboard watches.
   int   sel = 0;
   logic m_load_ir, m_sub, m_imm, m_rfa, m_we_rf, m_we_mem, m_load_pc, m_done;
   always_comb begin
      if (sel == 0) begin
         m_load_ir = bus0.load_ir; m_sub = bus0.sub; m_imm = bus0.ULA_din2_sel;
         m_rfa = bus0.RF_din_sel; m_we_rf = bus0.WE_RF; m_we_mem = bus0.WE_MEM;
         m_load_pc = bus0.load_pc; m_done = done0;
      end else begin
         m_load_ir = bus1.load_ir; m_sub = bus1.sub; m_imm = bus1.ULA_din2_sel;
         m_rfa = bus1.RF_din_sel; m_we_rf = bus1.WE_RF; m_we_mem = bus1.WE_MEM;
         m_load_pc = bus1.load_pc; m_done = done1;
      end
   end

   typedef struct packed {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
   } ins_t;

   typedef struct packed {
      int   cycles;   // FETCH to retire inclusive
      int   we_rf;    // WE_RF pulses inside the instruction
      int   we_mem;   // WE_MEM pulses inside the instruction
      int   sub_cyc;  // cycles with sub = 1
      int   we_at;    // cycle index of the write-enable pulse
      logic imm;      // ULA_din2_sel on the retire cycle
      logic rfa;      // RF_din_sel on the retire cycle
   } exp_t;

   ins_t  iq[$];
   exp_t  sb[$];
   string tq[$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_run(input logic v);
      if (sel == 0) run0 = v;
      else          run1 = v;
   endtask

   task automatic push(input string tag, input logic [6:0] op, input logic [2:0] fn3,
                       input logic fn7, input int cyc, input int wr, input int wm,
                       input int sc, input int at, input logic imm, input logic rfa);
      ins_t i;
      exp_t e;
      i = '{op: op, f3: fn3, f7: fn7};
      e = '{cycles: cyc, we_rf: wr, we_mem: wm, sub_cyc: sc, we_at: at, imm: imm, rfa: rfa};
      iq.push_back(i);
      sb.push_back(e);
      tq.push_back(tag);
   endtask

   // Runs the queued program on the selected instance. It presents each
   // encoding as the previous instruction retires, and it drops run on the
   // FETCH of the last instruction so that the core ends in IDLE.
   task automatic run_prog(input int budget);
      int    cyc = 0, wr = 0, wm = 0, sc = 0, at = 0, both = 0, n = 0;
      ins_t  i;
      exp_t  e;
      string t;
      i = iq.pop_front();
      {opc, f3, f7} = {i.op, i.f3, i.f7};
      set_run(1'b1);
      while (sb.size() > 0 && n < budget) begin
         tick();
         n++;
         if (m_load_ir) begin
            cyc = 0; wr = 0; wm = 0; sc = 0; at = 0;
            if (iq.size() == 0) set_run(1'b0);
         end
         cyc++;
         wr += int'(m_we_rf);
         wm += int'(m_we_mem);
         sc += int'(m_sub);
         if (m_we_rf || m_we_mem) at = cyc;
         if (m_we_rf && m_we_mem) both++;
         if (m_done) begin
            e = sb.pop_front();
            t = tq.pop_front();
            check({t, "_cycles"}, cyc, e.cycles);
            check({t, "_we_rf"},  wr,  e.we_rf);
            check({t, "_we_mem"}, wm,  e.we_mem);
            check({t, "_sub"},    sc,  e.sub_cyc);
            check({t, "_we_at"},  at,  e.we_at);
            check({t, "_din2"},   m_imm, e.imm);
            check({t, "_rfsel"},  m_rfa, e.rfa);
            check({t, "_ldpc"},   m_load_pc, 1'b1);
            if (iq.size() > 0) begin
               i = iq.pop_front();
               {opc, f3, f7} = {i.op, i.f3, i.f7};
            end
         end
      end
      check("prog_drained", sb.size(), 0);
      check("we_exclusive", both, 0);
      sb.delete();
      iq.delete();
      tq.delete();
   endtask

   localparam logic [6:0] OP_LD = 7'b0000011, OP_ST = 7'b0100011;
   localparam logic [6:0] OP_R  = 7'b0110011, OP_I  = 7'b0010011;

   initial begin
      rst0 = 1'b1; rst1 = 1'b1; run0 = 1'b1; run1 = 1'b0;
      opc = OP_LD; f3 = 3'b010; f7 = 1'b0;

      // Reset, then INIT pulses reset_pc once before IDLE.
      tick(); tick();
      rst0 = 1'b0; rst1 = 1'b0;
      #1;
      check("init_reset_pc", bus0.reset_pc, 1'b1);
      check("init_busy",     busy0, 1'b1);
      check("init_count",    cnt0, 16'd0);
      check("init_illegal",  ill0, 1'b0);
      check("init_we",       {bus0.WE_RF, bus0.WE_MEM}, 2'b00);
      tick();
      check("idle_reset_pc", bus0.reset_pc, 1'b0);
      check("idle_busy",     busy0, 1'b0);
      check("idle_load_ir",  bus0.load_ir, 1'b0);

      // Program: ld, ld, add, sub, st, addi, ld on MEM_WAIT=0.
      sel = 0;
      push("ld0",  OP_LD, 3'b010, 1'b0, 5, 1, 0, 0, 5, 1'b1, 1'b0);
      push("ld1",  OP_LD, 3'b010, 1'b0, 5, 1, 0, 0, 5, 1'b1, 1'b0);
      push("add",  OP_R,  3'b000, 1'b0, 4, 1, 0, 0, 4, 1'b0, 1'b1);
      push("sub",  OP_R,  3'b000, 1'b1, 4, 1, 0, 2, 4, 1'b0, 1'b1);
      push("st",   OP_ST, 3'b010, 1'b0, 4, 0, 1, 0, 4, 1'b1, 1'b1);
      push("addi", OP_I,  3'b000, 1'b0, 4, 1, 0, 0, 4, 1'b1, 1'b1);
      push("ld2",  OP_LD, 3'b010, 1'b0, 5, 1, 0, 0, 5, 1'b1, 1'b0);
      run_prog(100);
      tick();
      check("prog_count", cnt0, 16'd7);
      check("prog_idle",  busy0, 1'b0);

      // Illegal encoding: HALT is sticky and ignores run.
      opc = 7'b1100011; f3 = 3'b000; f7 = 1'b0;
      run0 = 1'b1;
      tick();
      check("ill_fetch",   bus0.load_ir, 1'b1);
      tick();
      check("ill_decode",  ill0, 1'b0);
      tick();
      check("halt_illegal", ill0, 1'b1);
      check("halt_busy",    busy0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         run0 = ~run0;
         tick();
         check("halt_hold", {busy0, ill0, bus0.load_ir, bus0.WE_RF, bus0.WE_MEM, bus0.load_pc},
               6'b010000);
      end
      check("halt_count", cnt0, 16'd7);
      rst0 = 1'b1; run0 = 1'b0;
      tick();
      check("rst_clr_illegal", ill0, 1'b0);
      check("rst_clr_count",   cnt0, 16'd0);
      check("rst_reset_pc",    bus0.reset_pc, 1'b1);
      rst0 = 1'b0;
      tick();

      // Run dropped during EXEC of addi: the instruction still completes.
      opc = OP_I; f3 = 3'b000; f7 = 1'b0;
      run0 = 1'b1;
      tick();
      check("addi_fetch", bus0.load_ir, 1'b1);
      tick();
      tick();
      check("addi_exec_imm", bus0.ULA_din2_sel, 1'b1);
      run0 = 1'b0;
      tick();
      check("addi_wb", {bus0.WE_RF, done0, bus0.load_pc}, 3'b111);
      tick();
      check("addi_idle",  busy0, 1'b0);
      check("addi_count", cnt0, 16'd1);
      tick();
      check("addi_stays_idle", bus0.load_ir, 1'b0);

      // Reset during the MEM cycle of st: nothing commits.
      opc = OP_ST; f3 = 3'b010;
      run0 = 1'b1;
      tick(); tick(); tick();
      run0 = 1'b0;
      @(posedge clk);
      #1 rst0 = 1'b1;
      @(negedge clk);
      check("rst_mem_busy",   busy0, 1'b1);
      check("rst_mem_we",     {bus0.WE_MEM, bus0.WE_RF}, 2'b00);
      check("rst_mem_retire", {done0, bus0.load_pc}, 2'b00);
      tick();
      check("rst_mem_init",  bus0.reset_pc, 1'b1);
      check("rst_mem_count", cnt0, 16'd0);
      rst0 = 1'b0;
      tick();
      check("rst_mem_idle", {busy0, bus0.WE_MEM}, 2'b00);

      // MEM_WAIT=3: st has 4 MEM cycles and writes in the last one; ld takes 8.
      sel = 1;
      push("w_st", OP_ST, 3'b010, 1'b0, 7, 0, 1, 0, 7, 1'b1, 1'b1);
      push("w_ld", OP_LD, 3'b010, 1'b0, 8, 1, 0, 0, 8, 1'b1, 1'b0);
      run_prog(100);
      tick();
      check("w_count", cnt1, 3'd2);

      // Six more retirements wrap the 3-bit counter from 7 to 0.
      for (int k = 0; k < 6; k++)
         push("w_addi", OP_I, 3'b000, 1'b0, 4, 1, 0, 0, 4, 1'b1, 1'b1);
      run_prog(200);
      tick();
      check("wrap_count", cnt1, 3'd0);
      check("wrap_idle",  busy1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
